// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main memory between the instruction cache
// (read-only) and the data cache (read/write), one block transfer at a time.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, the dcache wins every tie in IDLE.
//   defined   : a tie goes to the requester not recorded in last_grant.
//
// Handshake (cache side): a cache raises its request (i_read / d_read / d_write)
// and holds it until its busywait drops. Busywait is low for exactly the x_DONE
// cycle, and the registered x_readdata is valid in that cycle.
// Handshake (memory side): mem_read / mem_write and the address/data are
// registered at grant and held until mem_busywait is seen low at a posedge
// after at least MIN_WAIT cycles in x_REQ. Strobes are then low for at least
// one cycle (x_DONE) before the next grant.
//
// dbg_state_o = {last_grant (0 = icache, 1 = dcache), fsm state[2:0]}.
module mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 128,
  parameter int MIN_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              pc_busy,
  output logic [3:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    D_REQ  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Counter only needs to reach MIN_WAIT; it saturates there.
  localparam int              CNT_W   = $clog2(MIN_WAIT + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
  logic [DATA_W-1:0]   i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0]   d_readdata_q, d_readdata_d;

  logic i_req;
  logic d_req;
  logic tie_to_d;
  logic pick_d;
  logic mem_done;

  assign i_req    = i_read;
  assign d_req    = d_read | d_write;
  assign mem_done = ~mem_busywait & (cnt_q >= MIN_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on ties: whoever was not granted last wins.
  assign tie_to_d = (last_grant_q == GRANT_I);
`else
  // Fixed priority: the dcache wins every tie.
  assign tie_to_d = 1'b1;
`endif

  assign pick_d = d_req & (~i_req | tie_to_d);

  // Next-state and datapath: grant in IDLE, wait for memory in x_REQ, one-cycle x_DONE.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_d) begin
          // d_read & d_write together is treated as a write.
          state_d         = D_REQ;
          last_grant_d    = GRANT_D;
          mem_address_d   = d_address;
          mem_writedata_d = d_writedata;
          mem_write_d     = d_write;
          mem_read_d      = ~d_write;
        end else if (i_req) begin
          state_d       = I_REQ;
          last_grant_d  = GRANT_I;
          mem_address_d = i_address;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
        end
      end
      I_REQ: begin
        cnt_d = (cnt_q >= MIN_CNT) ? cnt_q : cnt_q + CNT_ONE;
        if (mem_done) begin
          state_d      = I_DONE;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          i_readdata_d = mem_readdata;
        end
      end
      D_REQ: begin
        cnt_d = (cnt_q >= MIN_CNT) ? cnt_q : cnt_q + CNT_ONE;
        if (mem_done) begin
          state_d     = D_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Writes leave d_readdata untouched.
          if (mem_read_q) begin
            d_readdata_d = mem_readdata;
          end
        end
      end
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous active-low reset aborts any transfer.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      last_grant_q    <= GRANT_I;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
    end
  end

  assign i_busywait    = i_read & (state_q != I_DONE);
  assign d_busywait    = (d_read | d_write) & (state_q != D_DONE);
  assign pc_busy       = i_busywait | d_busywait;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;
  assign dbg_state_o   = {last_grant_q, state_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transfers against a small busy-counting
// memory model. Memory operations and cache completions are checked by
// monitors that pop expected values pushed by the stimulus.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 128;
  localparam int OP_W   = 1 + ADDR_W + DATA_W;

  logic              CLK;
  logic              RESET;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;
  logic              pc_busy;
  logic [3:0]        dbg_state_o;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MIN_WAIT(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .pc_busy(pc_busy), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by time limit, required end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [OP_W-1:0]   exp_q[$];
  logic [DATA_W-1:0] exp_i_q[$];
  logic [DATA_W-1:0] exp_d_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_data(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem_arr [64];
  int mem_lat;
  int mem_cnt;
  bit mem_active;

  initial begin
    mem_busywait = 1'b0;
    mem_readdata = '0;
    mem_active   = 1'b0;
    mem_cnt      = 0;
    forever begin
      @(negedge CLK);
      if (mem_read | mem_write) begin
        if (!mem_active) begin
          mem_active = 1'b1;
          mem_cnt    = mem_lat;
        end
        mem_readdata = mem_arr[mem_address];
        if (mem_cnt > 0) begin
          mem_busywait = 1'b1;
          mem_cnt--;
        end else begin
          mem_busywait = 1'b0;
          if (mem_write) mem_arr[mem_address] = mem_writedata;
        end
      end else begin
        mem_active   = 1'b0;
        mem_busywait = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  // Memory-side monitor: each new strobe is one operation, compared in order.
  initial begin
    logic prev;
    logic [OP_W-1:0] got;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if ((mem_read | mem_write) && !prev) begin
        got = {mem_write, mem_address, (mem_write ? mem_writedata : {DATA_W{1'b0}})};
        check_int("strobe_exclusive", int'(mem_read & mem_write), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_op: got %0h required no operation", got);
        end else begin
          check_data("mem_op", got, exp_q.pop_front());
        end
      end
      prev = mem_read | mem_write;
    end
  end

  // Cache-side monitor: a held request with busywait low is a completion.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET && i_read && !i_busywait) begin
        if (exp_i_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_i_done: got %0h required no completion", i_readdata);
        end else check_data("i_readdata", OP_W'(i_readdata), OP_W'(exp_i_q.pop_front()));
      end
      if (RESET && (d_read | d_write) && !d_busywait) begin
        if (exp_d_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_d_done: got %0h required no completion", d_readdata);
        end else check_data("d_readdata", OP_W'(d_readdata), OP_W'(exp_d_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic i_txn(input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    i_read    = 1'b1;
    i_address = a;
    do begin
      @(negedge CLK);
      n++;
    end while (i_busywait && n < 300);
    check_int("i_txn_timeout", int'(i_busywait), 0);
    #1 i_read = 1'b0;
  endtask

  task automatic d_txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    int n;
    n = 0;
    d_write     = wr;
    d_read      = ~wr;
    d_address   = a;
    d_writedata = wd;
    do begin
      @(negedge CLK);
      n++;
    end while (d_busywait && n < 300);
    check_int("d_txn_timeout", int'(d_busywait), 0);
    #1;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check_int("reset_pulse_state", int'(dbg_state_o), 0);
    #1 RESET = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    bit  pc_ok;
    RESET = 1'b0; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    mem_lat = 1;
    for (int i = 0; i < 64; i++) mem_arr[i] = {16{8'(i)}};
    mem_arr[5] = {16{8'hA5}};

    // Reset values
    repeat (3) @(negedge CLK);
    check_int("rst_mem_read", int'(mem_read), 0);
    check_int("rst_mem_write", int'(mem_write), 0);
    check_int("rst_mem_address", int'(mem_address), 0);
    check_data("rst_mem_writedata", OP_W'(mem_writedata), '0);
    check_data("rst_i_readdata", OP_W'(i_readdata), '0);
    check_data("rst_d_readdata", OP_W'(d_readdata), '0);
    check_int("rst_i_busywait", int'(i_busywait), 0);
    check_int("rst_d_busywait", int'(d_busywait), 0);
    check_int("rst_pc_busy", int'(pc_busy), 0);
    check_int("rst_dbg_state", int'(dbg_state_o), 0);
    #1 RESET = 1'b1;

    // Lone icache read, memory busy for 40 cycles
    mem_lat = 40;
    exp_q.push_back({1'b0, 6'h05, {DATA_W{1'b0}}});
    exp_i_q.push_back({16{8'hA5}});
    @(negedge CLK);
    #1 i_address = 6'h05; i_read = 1'b1;
    @(negedge CLK);
    check_int("t1_mem_read", int'(mem_read), 1);
    check_int("t1_mem_address", int'(mem_address), 5);
    check_int("t1_i_busywait", int'(i_busywait), 1);
    check_int("t1_pc_busy", int'(pc_busy), 1);
    n = 0;
    pc_ok = 1'b1;
    while (i_busywait && n < 200) begin
      @(negedge CLK);
      n++;
      if (pc_busy !== i_busywait) pc_ok = 1'b0;
    end
    check_int("t1_wait_cycles", n, 41);
    check_int("t1_pc_tracks", int'(pc_ok), 1);
    check_int("t1_mem_read_in_done", int'(mem_read), 0);
    check_int("t1_pc_busy_low", int'(pc_busy), 0);
    @(negedge CLK);
    check_int("t1_busy_one_cycle", int'(i_busywait), 1);
    #1 i_read = 1'b0;
    @(negedge CLK);
    check_int("t1_idle_busy", int'(i_busywait), 0);
    check_int("t1_idle_strobe", int'(mem_read), 0);

    // Same-cycle tie: dcache write first, then icache read
    mem_lat = 5;
    exp_q.push_back({1'b1, 6'h03, 128'h1234});
    exp_q.push_back({1'b0, 6'h01, {DATA_W{1'b0}}});
    exp_d_q.push_back('0);
    exp_i_q.push_back({16{8'h01}});
    @(negedge CLK);
    #1;
    fork
      i_txn(6'h01);
      d_txn(1'b1, 6'h03, 128'h1234);
    join

    // dcache read arriving during I_REQ waits for I_DONE
    mem_lat = 10;
    exp_q.push_back({1'b0, 6'h02, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h07, {DATA_W{1'b0}}});
    exp_i_q.push_back({16{8'h02}});
    exp_d_q.push_back({16{8'h07}});
    @(negedge CLK);
    #1;
    fork
      i_txn(6'h02);
      begin
        repeat (3) @(negedge CLK);
        #1 d_read = 1'b1; d_address = 6'h07;
        @(negedge CLK);
        check_int("t3_d_busywait", int'(d_busywait), 1);
        check_int("t3_state_i_req", int'(dbg_state_o[2:0]), 1);
        check_int("t3_mem_read_held", int'(mem_read), 1);
        check_int("t3_mem_address_held", int'(mem_address), 2);
        n = 0;
        while (d_busywait && n < 300) begin
          @(negedge CLK);
          n++;
        end
        check_int("t3_d_timeout", int'(d_busywait), 0);
        #1 d_read = 1'b0;
      end
    join

    // Reset at cycle 10 of D_REQ, write held and reissued afterwards
    mem_lat = 30;
    exp_q.push_back({1'b1, 6'h09, 128'hDEAD_BEEF});
    exp_q.push_back({1'b1, 6'h09, 128'hDEAD_BEEF});
    exp_d_q.push_back('0);
    @(negedge CLK);
    #1 d_write = 1'b1; d_address = 6'h09; d_writedata = 128'hDEAD_BEEF;
    repeat (10) @(negedge CLK);
    check_int("t4_in_d_req", int'(dbg_state_o[2:0]), 2);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check_int("t4_state_idle", int'(dbg_state_o), 0);
    check_int("t4_mem_write", int'(mem_write), 0);
    check_data("t4_d_readdata", OP_W'(d_readdata), '0);
    check_int("t4_d_busywait", int'(d_busywait), 1);
    #1 RESET = 1'b1;
    n = 0;
    while (d_busywait && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check_int("t4_d_timeout", int'(d_busywait), 0);
    #1 d_write = 1'b0;

    // Continuous ties over four grants, starting from a fresh reset
    pulse_reset();
    mem_lat = 3;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back({1'b0, 6'h0A, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h14, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h0B, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h15, {DATA_W{1'b0}}});
`else
    exp_q.push_back({1'b0, 6'h0A, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h0B, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h14, {DATA_W{1'b0}}});
    exp_q.push_back({1'b0, 6'h15, {DATA_W{1'b0}}});
`endif
    exp_d_q.push_back({16{8'h0A}});
    exp_d_q.push_back({16{8'h0B}});
    exp_i_q.push_back({16{8'h14}});
    exp_i_q.push_back({16{8'h15}});
    fork
      begin
        i_txn(6'h14);
        i_txn(6'h15);
      end
      begin
        d_txn(1'b0, 6'h0A, '0);
        d_txn(1'b0, 6'h0B, '0);
      end
    join

    // MIN_WAIT: memory never busy, completion not accepted in the entry cycle
    mem_lat = 0;
    exp_q.push_back({1'b0, 6'h04, {DATA_W{1'b0}}});
    exp_i_q.push_back({16{8'h04}});
    @(negedge CLK);
    #1 i_read = 1'b1; i_address = 6'h04;
    @(negedge CLK);
    check_int("t6_entry_strobe", int'(mem_read), 1);
    check_int("t6_entry_busy", int'(i_busywait), 1);
    @(negedge CLK);
    check_int("t6_second_strobe", int'(mem_read), 1);
    check_int("t6_second_busy", int'(i_busywait), 1);
    @(negedge CLK);
    check_int("t6_done_busy", int'(i_busywait), 0);
    check_int("t6_done_strobe", int'(mem_read), 0);
    #1 i_read = 1'b0;

    // Drain and report
    repeat (5) @(negedge CLK);
    check_int("exp_q_empty", exp_q.size(), 0);
    check_int("exp_i_q_empty", exp_i_q.size(), 0);
    check_int("exp_d_q_empty", exp_d_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
